mem_access_arb: RTL and testbench
=================================

# mem_access_arb

Two-port access arbiter sitting directly upstream of the 32x8 data memory. It accepts requests from the instruction-fetch port (read-only) and the data port (read/write), round-robin arbitrates them, and drives the memory's `read`/`write`/`addr`/`data_in` strobes. It guarantees that `read` and `write` are never asserted together. It returns read data and a one-cycle acknowledge to the winning requester.

## Interface
- `ADDR_W`, default 5: memory address width.
- `DATA_W`, default 8: memory data width.

- `clk`  in  1: single system clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `if_req`  in  1: fetch read request; level, held until `if_ack`.
- `if_addr`  in  ADDR_W: fetch address; stable while `if_req` is high.
- `if_ack`  out  1: one-cycle pulse; transaction complete.
- `if_rdata`  out  DATA_W: fetch read data; valid while `if_ack` is high, held afterwards.
- `d_req`  in  1: data request; level, held until `d_ack`.
- `d_we`  in  1: 1 = write, 0 = read; stable while `d_req` is high.
- `d_addr`  in  ADDR_W: data address; stable while `d_req` is high.
- `d_wdata`  in  DATA_W: write data; stable while `d_req` is high.
- `d_ack`  out  1: one-cycle completion pulse.
- `d_rdata`  out  DATA_W: data read result; valid while `d_ack` is high, held afterwards.
- `mem_read`  out  1: memory read strobe.
- `mem_write`  out  1: memory write strobe.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_data_in`  out  DATA_W: memory write data.
- `mem_data_out`  in  DATA_W: memory read data; updated at the edge ending a `read` cycle.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
  - IDLE: if any request is pending, pick a winner.
    - Latch the winner's addr, wdata and we into the `mem_*` registers.
    - Set `mem_read` = !we or `mem_write` = we.
    - Go to ISSUE.
    - The fetch port always has we = 0.
  - ISSUE: exactly one of `mem_read`/`mem_write` is high for exactly this one cycle. Go to RESP.
  - RESP: pulse the winner's ack.
    - For a read, the winner's rdata is driven from `mem_data_out` and captured into its hold register at the edge ending RESP.
    - A write leaves the rdata hold registers unchanged.
    - Go to IDLE.
- Arbitration uses a `last_grant` bit (0 = data, 1 = fetch).
  - When only one request is pending, that port wins.
  - When both are pending, the port not granted last wins.
  - `last_grant` updates on every grant.
- The `mem_*` registers are driven only from IDLE. `mem_read`/`mem_write` are 0 in IDLE and RESP.
- Invariant: `mem_read && mem_write` is never 1. This holds from reset onward.
- If a request drops before its ack (protocol violation), the transaction already granted still completes and its ack still pulses. No new grant is made for the dropped port.
- Only one transaction is in flight at a time. There is no forwarding or write buffering.

## Timing
- A request is sampled in IDLE at cycle T.
  - `mem_*` strobe high in T+1 (ISSUE).
  - Ack high in T+2 (RESP).
  - The next grant can occur at T+3 at the earliest.
- Sustained throughput is one access per 3 cycles.
- The requester deasserts req at the edge ending its ack cycle. A req still high in the following IDLE is treated as a new request.
- Read data seen by the requester in RESP equals memory content at `mem_addr` as of the ISSUE cycle.
- A write is visible to a read issued at any later ISSUE.
- Reset values, applied immediately on `rst` rise regardless of clock:
  - state = IDLE
  - `mem_read` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_data_in` = 0
  - `if_ack` = 0, `d_ack` = 0
  - `if_rdata` = 0, `d_rdata` = 0
  - `last_grant` = 0 (fetch wins the first tie)
  - `busy` = 0
- Reset mid-transaction aborts it with no ack.
  - A write aborted in ISSUE may or may not have reached memory.
  - After reset deasserts, requesters must re-request.

## Test plan
- Reset, then `d_req`=1, `d_we`=1, `d_addr`=5, `d_wdata`=8'hA5:
  - `mem_write`=1, `mem_addr`=5, `mem_data_in`=A5 exactly one cycle after sampling.
  - `d_ack` the following cycle; memory[5]=A5.
- Data read of addr 5 after the previous write -> `mem_read` 1 cycle, then `d_ack`=1 with `d_rdata`=A5. `d_rdata` stays A5 after the ack drops.
- `if_req` and `d_req` both high from reset (`if_addr`=3, `d_addr`=7, both reads) and held:
  - Fetch granted first (`if_ack` at cycle 3).
  - Data granted second (`d_ack` at cycle 6).
  - A re-asserted fetch is granted third: strict alternation.
- `d_req` held high continuously with `if_req` high -> grants alternate data/fetch. The fetch port never waits more than one data transaction.
- Assert `rst` during ISSUE of a read -> `mem_read`, `d_ack`, `busy` go to 0 immediately. No ack after reset release; state IDLE.
- Random req/we/addr traffic for 10k cycles:
  - `mem_read && mem_write` never 1.
  - Every ack preceded by exactly one strobe.
  - Reads match a reference memory model.

Source files
------------

// File: rtl/mem_access_arb.sv
// mem_access_arb
//   Two-port round-robin arbiter in front of a single-ported data memory.
//   One transaction in flight at a time: IDLE (grant) -> ISSUE (strobe)
//   -> RESP (ack), so the sustained rate is one access every three cycles.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   if_req/if_addr      fetch read request (level, held until if_ack)
//   if_ack/if_rdata     fetch completion pulse and read data (held)
//   d_req/d_we/d_addr/d_wdata  data request (read or write)
//   d_ack/d_rdata       data completion pulse and read data (held)
//   mem_read/mem_write  memory strobes, never both high
//   mem_addr/mem_data_in memory address and write data
//   mem_data_out        memory read data, valid after a read cycle
//   busy                high whenever a transaction is in progress
module mem_access_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_grant;   // 1 = fetch won the previous grant
    logic              cur_fetch;    // owner of the transaction in flight
    logic              cur_we;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              any_req;
    logic              grant_fetch;

    // Fetch wins if it is alone, or on a tie when data was granted last.
    always_comb begin
        any_req     = if_req | d_req;
        grant_fetch = if_req & (~d_req | ~last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side registers: loaded at grant, strobes dropped after ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            cur_fetch   <= 1'b0;
            cur_we      <= 1'b0;
            last_grant  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_fetch  <= grant_fetch;
                        last_grant <= grant_fetch;
                        if (grant_fetch) begin
                            cur_we      <= 1'b0;
                            mem_read    <= 1'b1;
                            mem_write   <= 1'b0;
                            mem_addr    <= if_addr;
                            mem_data_in <= '0;
                        end else begin
                            cur_we      <= d_we;
                            mem_read    <= ~d_we;
                            mem_write   <= d_we;
                            mem_addr    <= d_addr;
                            mem_data_in <= d_wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Read data is passed straight through during RESP and captured as
    // RESP ends, so the requester sees it in its ack cycle and afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == RESP && !cur_we) begin
            if (cur_fetch) if_rdata_q <= mem_data_out;
            else           d_rdata_q  <= mem_data_out;
        end
    end

    always_comb begin
        if_ack   = (state == RESP) &  cur_fetch;
        d_ack    = (state == RESP) & ~cur_fetch;
        if_rdata = (if_ack && !cur_we) ? mem_data_out : if_rdata_q;
        d_rdata  = (d_ack  && !cur_we) ? mem_data_out : d_rdata_q;
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_access_arb.sv
module tb_mem_access_arb;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out = '0;
    logic          busy;

    mem_access_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Memory device the DUT drives.
    logic [DW-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = DW'(i * 7 + 1);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr] = mem_data_in;
            if (mem_read)  mem_data_out = mem[mem_addr];
        end
    end

    // Transaction-level reference: a grant decided from the request levels
    // seen in an idle cycle produces a strobe one cycle later and the ack
    // the cycle after that; reads return the reference memory contents.
    logic [DW-1:0] ref_mem [32];
    int            m_phase;        // cycles into current transaction, 0 = none
    logic          m_fetch, m_we, m_last_fetch;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rd, m_d_rd;

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = DW'(i * 7 + 1);
        m_phase = 0; m_last_fetch = 1'b0; m_if_rd = '0; m_d_rd = '0;
        m_fetch = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_strobes", {mem_read, mem_write}, 0);
                chk("rst_acks", {if_ack, d_ack}, 0);
                m_phase = 0; m_last_fetch = 1'b0; m_if_rd = '0; m_d_rd = '0;
            end else begin
                chk("busy", busy, m_phase != 0);
                chk("mem_read", mem_read, m_phase == 1 && !m_we);
                chk("mem_write", mem_write, m_phase == 1 && m_we);
                chk("rw_exclusive", mem_read & mem_write, 0);
                if (m_phase == 1) begin
                    chk("mem_addr", mem_addr, m_addr);
                    if (m_we) chk("mem_data_in", mem_data_in, m_wdata);
                end
                chk("if_ack", if_ack, m_phase == 2 && m_fetch);
                chk("d_ack", d_ack, m_phase == 2 && !m_fetch);
                if (m_phase == 2 && !m_we) begin
                    if (m_fetch) m_if_rd = ref_mem[m_addr];
                    else         m_d_rd  = ref_mem[m_addr];
                end
                chk("if_rdata", if_rdata, m_if_rd);
                chk("d_rdata", d_rdata, m_d_rd);
                if (m_phase == 2) m_phase = 0;
                else if (m_phase == 1) begin
                    if (m_we) ref_mem[m_addr] = m_wdata;
                    m_phase = 2;
                end else if (if_req || d_req) begin
                    m_fetch = if_req && !(d_req && m_last_fetch);
                    m_last_fetch = m_fetch;
                    m_we    = m_fetch ? 1'b0 : d_we;
                    m_addr  = m_fetch ? if_addr : d_addr;
                    m_wdata = d_wdata;
                    m_phase = 1;
                end
            end
        end
    end

    task automatic do_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd);
        bit got = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        rd = '0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (d_ack) begin got = 1; rd = d_rdata; end
        end
        if (!got) chk("d_ack_timeout", 0, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic fetch_agent(input int ncyc);
        int t0 = cyc;
        while (cyc - t0 < ncyc) begin
            bit got = 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            if_addr = AW'($urandom); if_req = 1'b1;
            for (int i = 0; i < 12 && !got; i++) begin
                @(negedge clk);
                if (if_ack) got = 1;
            end
            if (!got) chk("if_ack_timeout", 0, 1);
            @(posedge clk); #1;
            if_req = 1'b0;
        end
    endtask

    task automatic data_agent(input int ncyc);
        int t0 = cyc;
        logic [DW-1:0] rd;
        while (cyc - t0 < ncyc) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_d(1'($urandom), AW'($urandom), DW'($urandom), rd);
        end
    endtask

    initial begin
        logic [DW-1:0] rd;
        int n, t_if1, t_if2, t_d1, n_if, n_d;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_data_in", mem_data_in, 0);
        rst = 1'b0;

        // Write then read back.
        do_d(1'b1, 5'd5, 8'hA5, rd);
        chk("mem5_written", mem[5], 8'hA5);
        do_d(1'b0, 5'd5, 8'h00, rd);
        chk("read_back", rd, 8'hA5);
        @(negedge clk);
        chk("d_rdata_held", d_rdata, 8'hA5);

        // Both requests high from reset and held: fetch, data, fetch.
        @(posedge clk); #1;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 5'd3;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd7;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0; t_if1 = 0; t_if2 = 0; t_d1 = 0; n_if = 0; n_d = 0;
        repeat (12) begin
            @(negedge clk);
            n++;
            if (if_ack) begin
                n_if++;
                if (n_if == 1) t_if1 = n;
                if (n_if == 2) t_if2 = n;
            end
            if (d_ack) begin
                n_d++;
                if (n_d == 1) t_d1 = n;
            end
        end
        chk("tie_fetch_first", t_if1, 3);
        chk("tie_data_second", t_d1, 6);
        chk("tie_fetch_third", t_if2, 9);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;

        // Request dropped during ISSUE still completes.
        repeat (2) @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd2;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dropped_req_ack", d_ack, 1);
        chk("dropped_req_rdata", d_rdata, 8'd15);

        // Reset during ISSUE of a read.
        repeat (2) @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd9;
        @(posedge clk); #2;
        chk("abort_strobe_pre", mem_read, 1);
        rst = 1'b1;
        #1;
        chk("abort_mem_read", mem_read, 0);
        chk("abort_d_ack", d_ack, 0);
        chk("abort_busy", busy, 0);
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_d = 0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack) n_d++;
        end
        chk("abort_no_ack", n_d, 0);

        // Random traffic.
        fork
            fetch_agent(10000);
            data_agent(10000);
        join
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
